// File: rtl/spi_frame_sequencer.sv
// Launches one SPI master frame per latched command word, captures each reply,
// and signals completion with a DONE pulse; per-frame timeout sets ERROR.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for TRIGGER; outputs hold last sequence status
// LOAD      | present word[FRAME_IDX] on SPI_DATA_IN, START low
// PULSE     | hold SPI_START high for 3 cycles
// WAIT_BUSY | wait for master BUSY to rise (timed)
// WAIT_DONE | wait for BUSY low with VALID, capture reply (timed)
// GAP       | chip-select idle gap between frames
// FINISH    | one-cycle DONE pulse
module spi_frame_sequencer #(
    parameter int DATA_BIT_WIDTH = 16,
    parameter int NUM_WORDS      = 4,
    parameter int GAP_CYCLES     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                RST,
    input  logic                                TRIGGER,
    input  logic [NUM_WORDS*DATA_BIT_WIDTH-1:0] CMDS,
    output logic                                SPI_START,
    output logic [DATA_BIT_WIDTH-1:0]           SPI_DATA_IN,
    input  logic                                SPI_BUSY,
    input  logic                                SPI_VALID,
    input  logic [DATA_BIT_WIDTH-1:0]           SPI_DATA_OUT,
    output logic [NUM_WORDS*DATA_BIT_WIDTH-1:0] RESULTS,
    output logic [3:0]                          FRAME_IDX,
    output logic                                BUSY,
    output logic                                DONE,
    output logic                                ERROR
);

    localparam int W       = DATA_BIT_WIDTH;
    localparam int VEC_W   = NUM_WORDS * DATA_BIT_WIDTH;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(2);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX     = 4'(NUM_WORDS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_PULSE     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] cmds_q, cmds_d;
    logic [W-1:0]     data_in_q, data_in_d;
    logic [VEC_W-1:0] results_q, results_d;
    logic [3:0]       frame_idx_q, frame_idx_d;
    logic             error_q, error_d;
    logic [W-1:0]     next_word;

    // frame_idx_q already points at the upcoming frame when GAP expires
    always_comb begin
        next_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (frame_idx_q == 4'(i)) next_word = cmds_q[i*W +: W];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmds_d      = cmds_q;
        data_in_d   = data_in_q;
        results_d   = results_q;
        frame_idx_d = frame_idx_q;
        error_d     = error_q;
        case (state_q)
            S_IDLE: begin
                if (TRIGGER) begin
                    cmds_d      = CMDS;
                    data_in_d   = CMDS[W-1:0];
                    frame_idx_d = '0;
                    error_d     = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = PULSE_LAST;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_BUSY;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_BUSY: begin
                if (SPI_BUSY) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!SPI_BUSY && SPI_VALID) begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (frame_idx_q == 4'(i)) results_d[i*W +: W] = SPI_DATA_OUT;
                    end
                    if (frame_idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        frame_idx_d = frame_idx_q + 4'd1;
                        cnt_d       = GAP_LAST;
                        state_d     = S_GAP;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    data_in_d = next_word;
                    state_d   = S_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FINISH: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmds_q      <= '0;
            data_in_q   <= '0;
            results_q   <= '0;
            frame_idx_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmds_q      <= cmds_d;
            data_in_q   <= data_in_d;
            results_q   <= results_d;
            frame_idx_q <= frame_idx_d;
            error_q     <= error_d;
        end
    end

    // Decoded from state so START drops on the same edge reset is taken
    assign SPI_START   = (state_q == S_PULSE);
    assign SPI_DATA_IN = data_in_q;
    assign RESULTS     = results_q;
    assign FRAME_IDX   = frame_idx_q;
    assign BUSY        = (state_q != S_IDLE);
    assign DONE        = (state_q == S_FINISH);
    assign ERROR       = error_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: a behavioural SPI master answers frames,
// expectations are queued at trigger time and checked by monitors on START and DONE.
module tb_spi_frame_sequencer;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int GAP  = 32;
    localparam int TO   = 1024;
    localparam int N1   = 1;
    localparam int GAP1 = 1;
    localparam int TO1  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           RST, TRIGGER, TRIGGER1;
    logic [N*W-1:0] CMDS;
    logic [W-1:0]   CMDS1;
    logic           SPI_START, SPI_START1;
    logic [W-1:0]   SPI_DATA_IN, SPI_DATA_IN1;
    logic           SPI_BUSY = 1'b0, SPI_VALID = 1'b0, SPI_BUSY1 = 1'b0, SPI_VALID1 = 1'b0;
    logic [W-1:0]   SPI_DATA_OUT = '0, SPI_DATA_OUT1 = '0;
    logic [N*W-1:0] RESULTS;
    logic [W-1:0]   RESULTS1;
    logic [3:0]     FRAME_IDX, FRAME_IDX1;
    logic           BUSY, DONE, ERROR, BUSY1, DONE1, ERROR1;

    spi_frame_sequencer #(.DATA_BIT_WIDTH(W), .NUM_WORDS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .RST(RST), .TRIGGER(TRIGGER), .CMDS(CMDS),
        .SPI_START(SPI_START), .SPI_DATA_IN(SPI_DATA_IN), .SPI_BUSY(SPI_BUSY),
        .SPI_VALID(SPI_VALID), .SPI_DATA_OUT(SPI_DATA_OUT), .RESULTS(RESULTS),
        .FRAME_IDX(FRAME_IDX), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR));

    spi_frame_sequencer #(.DATA_BIT_WIDTH(W), .NUM_WORDS(N1), .GAP_CYCLES(GAP1), .TIMEOUT_CYCLES(TO1)) u_dut1 (
        .clk(clk), .RST(RST), .TRIGGER(TRIGGER1), .CMDS(CMDS1),
        .SPI_START(SPI_START1), .SPI_DATA_IN(SPI_DATA_IN1), .SPI_BUSY(SPI_BUSY1),
        .SPI_VALID(SPI_VALID1), .SPI_DATA_OUT(SPI_DATA_OUT1), .RESULTS(RESULTS1),
        .FRAME_IDX(FRAME_IDX1), .BUSY(BUSY1), .DONE(DONE1), .ERROR(ERROR1));

    typedef struct { logic [W-1:0] word; logic [3:0] idx; } cmd_t;
    typedef struct { logic [N*W-1:0] res; logic err; logic chk_to; } seq_t;

    cmd_t         cmd_q[$];
    seq_t         seq_q[$];
    logic [W-1:0] model_res [N];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- master model for the 4-word instance ----------------
    int           m_phase = 0, m_cnt = 0, m_frame_no = 0, m_fail_frame = -1;
    bit           m_stuck = 1'b0;
    logic [W-1:0] m_cmd = '0;
    logic         m_start_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        SPI_VALID = 1'b0;
        if (SPI_START && !m_start_prev && m_phase == 0) begin
            m_cmd = SPI_DATA_IN;
            if (m_frame_no != m_fail_frame) begin
                m_phase = 1;
                m_cnt   = $urandom_range(4, 2);
            end else if (m_stuck) begin
                m_phase  = 3;
                SPI_BUSY = 1'b1;
            end
            m_frame_no++;
        end else if (m_phase == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
                SPI_BUSY = 1'b1;
                m_phase  = 2;
                m_cnt    = $urandom_range(20, 3);
            end
        end else if (m_phase == 2) begin
            m_cnt--;
            if (m_cnt == 0) begin
                SPI_BUSY     = 1'b0;
                SPI_VALID    = 1'b1;
                SPI_DATA_OUT = ~m_cmd;
                m_phase      = 0;
            end
        end else if (m_phase == 3 && !m_stuck) begin
            SPI_BUSY = 1'b0;
            m_phase  = 0;
        end
        m_start_prev = SPI_START;
    end

    // ---------------- master model for the single-word instance ----------------
    int           m1_cnt = 0;
    logic [W-1:0] m1_cmd = '0;
    logic         m1_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (SPI_START1 && !m1_prev) begin
            m1_cmd = SPI_DATA_IN1;
            m1_cnt = 5;
        end else if (m1_cnt > 0) begin
            m1_cnt--;
        end
        SPI_BUSY1     = (m1_cnt >= 2 && m1_cnt <= 4);
        SPI_VALID1    = (m1_cnt == 1);
        SPI_DATA_OUT1 = ~m1_cmd;
        m1_prev       = SPI_START1;
    end

    // ---------------- monitor / scoreboard, 4-word instance ----------------
    int   cyc = 0, rise_cyc = 0, wb_cyc = 0, fall_cyc = 0;
    bit   gap_armed = 1'b0;
    logic start_p = 1'b0, busyin_p = 1'b0, done_p = 1'b0;

    always @(negedge clk) begin
        cmd_t         ce;
        seq_t         se;
        logic [W-1:0] echo;
        cyc++;
        if (RST) begin
            cmd_q.delete();
            seq_q.delete();
            gap_armed = 1'b0;
        end else begin
            if (SPI_START && !start_p) begin
                if (cmd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: START rose at frame_idx %0d, required no frame", FRAME_IDX);
                end else begin
                    ce = cmd_q.pop_front();
                    check("data_in", 64'(SPI_DATA_IN), 64'(ce.word));
                    check("frame_idx", 64'(FRAME_IDX), 64'(ce.idx));
                    if (gap_armed) check("gap_cycles", 64'(cyc - fall_cyc), 64'(GAP + 2));
                end
                gap_armed = 1'b0;
                rise_cyc  = cyc;
            end
            if (!SPI_START && start_p) begin
                check("start_width", 64'(cyc - rise_cyc), 64'(3));
                wb_cyc = cyc;
            end
            if (!SPI_BUSY && busyin_p && BUSY) begin
                fall_cyc  = cyc;
                gap_armed = 1'b1;
                if (SPI_VALID) begin
                    echo = ~SPI_DATA_OUT;
                    check("data_in_hold", 64'(SPI_DATA_IN), 64'(echo));
                end
            end
            if (DONE) begin
                if (seq_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: DONE high, required no pending sequence");
                end else begin
                    se = seq_q.pop_front();
                    check("results", 64'(RESULTS), 64'(se.res));
                    check("error", 64'(ERROR), 64'(se.err));
                    if (se.chk_to) check("timeout_latency", 64'(cyc - wb_cyc), 64'(TO));
                    check("frames_outstanding", 64'(cmd_q.size()), 64'(0));
                end
                gap_armed = 1'b0;
            end
            if (done_p && !DONE) check("busy_after_done", 64'(BUSY), 64'(0));
        end
        start_p  = SPI_START;
        busyin_p = SPI_BUSY;
        done_p   = DONE;
    end

    // ---------------- monitor, single-word instance ----------------
    int           cyc1 = 0, done1_cnt = 0, start1_cnt = 0, last_done1 = -1;
    logic         start1_p = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] exp1;
        cyc1++;
        if (!RST) begin
            if (SPI_START1 && !start1_p) begin
                start1_cnt++;
                if (last_done1 >= 0) check("retrigger_spacing", 64'(cyc1 - last_done1), 64'(3));
            end
            if (DONE1) begin
                done1_cnt++;
                last_done1 = cyc1;
                exp1 = ~CMDS1;
                check("results1", 64'(RESULTS1), 64'(exp1));
                check("error1", 64'(ERROR1), 64'(0));
            end
        end
        start1_p = SPI_START1;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (BUSY && k < limit) begin
            tick();
            k++;
        end
        if (BUSY) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_wait: BUSY still 1 after %0d cycles, required 0", limit);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 64'(SPI_START), 64'(0));
        check({tag, "_data_in"}, 64'(SPI_DATA_IN), 64'(0));
        check({tag, "_results"}, 64'(RESULTS), 64'(0));
        check({tag, "_frame_idx"}, 64'(FRAME_IDX), 64'(0));
        check({tag, "_busy"}, 64'(BUSY), 64'(0));
        check({tag, "_done"}, 64'(DONE), 64'(0));
        check({tag, "_error"}, 64'(ERROR), 64'(0));
    endtask

    // fail_frame < 0: all frames answered; otherwise that frame never completes
    task automatic run_seq(input int fail_frame, input bit stuck, input bit noise);
        cmd_t         ce;
        seq_t         se;
        logic [W-1:0] w;
        int           sent;
        wait_idle(6000);
        m_frame_no   = 0;
        m_fail_frame = fail_frame;
        m_stuck      = stuck;
        TRIGGER      = 1'b1;
        sent = (fail_frame < 0) ? N : fail_frame + 1;
        se.res = '0;
        for (int i = 0; i < N; i++) begin
            w = CMDS[i*W +: W];
            if (i < sent) begin
                ce.word = w;
                ce.idx  = 4'(i);
                cmd_q.push_back(ce);
            end
            if (fail_frame < 0 || i < fail_frame) model_res[i] = ~w;
            se.res[i*W +: W] = model_res[i];
        end
        se.err    = (fail_frame >= 0);
        se.chk_to = (fail_frame >= 0) && !stuck;
        seq_q.push_back(se);
        tick();
        TRIGGER = 1'b0;
        if (noise) begin
            for (int k = 0; k < 40; k++) begin
                TRIGGER = 1'($urandom_range(1, 0));
                CMDS    = {$urandom, $urandom};
                tick();
            end
        end
        TRIGGER = 1'b0;
        wait_idle(6000);
        m_stuck = 1'b0;
    endtask

    initial begin
        cmd_t ce;
        int   k;
        RST = 1'b1; TRIGGER = 1'b0; TRIGGER1 = 1'b0; CMDS = '0; CMDS1 = '0;
        for (int i = 0; i < N; i++) model_res[i] = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        RST = 1'b0;
        tick();

        CMDS = 64'hA5A5_1234_8800_9000;
        run_seq(-1, 1'b0, 1'b0);
        check("directed_results", 64'(RESULTS), 64'h5A5A_EDCB_77FF_6FFF);

        run_seq(0, 1'b0, 1'b0);
        run_seq(-1, 1'b0, 1'b1);
        CMDS = {$urandom, $urandom};
        run_seq(2, 1'b1, 1'b0);

        for (int s = 0; s < 8; s++) begin
            int r;
            int ff;
            r  = $urandom_range(9, 0);
            ff = (r == 0) ? $urandom_range(N - 1, 0) : -1;
            CMDS = {$urandom, $urandom};
            run_seq(ff, (r == 0) ? 1'($urandom_range(1, 0)) : 1'b0, 1'($urandom_range(1, 0)));
        end

        // reset while frame 1 is in flight
        wait_idle(6000);
        CMDS = {$urandom, $urandom};
        m_frame_no = 0; m_fail_frame = -1; m_stuck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ce.word = CMDS[i*W +: W];
            ce.idx  = 4'(i);
            cmd_q.push_back(ce);
        end
        TRIGGER = 1'b1;
        tick();
        TRIGGER = 1'b0;
        k = 0;
        while (!(FRAME_IDX == 4'd1 && SPI_BUSY && !SPI_START) && k < 2000) begin
            tick();
            k++;
        end
        check("reached_frame1", 64'(k < 2000), 64'(1));
        tick();
        RST = 1'b1;
        tick();
        check_reset_outputs("midreset");
        RST = 1'b0;
        for (int i = 0; i < N; i++) model_res[i] = '0;
        repeat (50) tick();
        CMDS = {$urandom, $urandom};
        run_seq(-1, 1'b0, 1'b0);

        // single-word instance, TRIGGER held high
        CMDS1    = 16'($urandom);
        TRIGGER1 = 1'b1;
        repeat (60) tick();
        TRIGGER1 = 1'b0;
        repeat (20) tick();
        check("burst_dones", 64'(done1_cnt), 64'(8));
        check("burst_starts", 64'(start1_cnt), 64'(8));

        repeat (5) tick();
        check("pending_sequences", 64'(seq_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_frame_sequencer.md
# spi_frame_sequencer

Command sequencer that sits directly upstream of the SPI master on the robot FPGA. It walks a fixed list of command words and launches one SPI frame per word through the master's START/DATA_IN interface. It captures each received word from DATA_OUT/VALID and presents the full result set with a completion pulse. It is used for periodic motor-driver register polling, enforcing an inter-frame chip-select gap and a per-frame timeout.

## Interface
- DATA_BIT_WIDTH, 16: width of one SPI frame; must match the SPI master instance.
- NUM_WORDS, 4: frames per sequence, 1..16.
- GAP_CYCLES, 32: idle clk cycles between frames, ≥1.
- TIMEOUT_CYCLES, 1024: max clk cycles to wait for master BUSY rise or completion, ≥8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- TRIGGER  in  1  level; sampled high in IDLE starts a sequence.
- CMDS  in  NUM_WORDS*DATA_BIT_WIDTH  command words; word i = bits [i*W +: W], sent in order 0..NUM_WORDS-1.
- SPI_START  out  1  to master START.
- SPI_DATA_IN  out  DATA_BIT_WIDTH  to master DATA_IN.
- SPI_BUSY  in  1  from master BUSY.
- SPI_VALID  in  1  from master VALID.
- SPI_DATA_OUT  in  DATA_BIT_WIDTH  from master DATA_OUT.
- RESULTS  out  NUM_WORDS*DATA_BIT_WIDTH  captured replies, same packing as CMDS.
- FRAME_IDX  out  4  index of frame in progress.
- BUSY  out  1  high whenever not IDLE.
- DONE  out  1  one-cycle pulse at sequence end.
- ERROR  out  1  status of last sequence; 1 = timed out.

## Operation
- States: IDLE, LOAD, PULSE, WAIT_BUSY, WAIT_DONE, GAP, FINISH.
- IDLE: BUSY=0. TRIGGER=1 latches CMDS into an internal copy, clears ERROR, sets FRAME_IDX=0, and goes to LOAD. CMDS changes after the latch have no effect on the running sequence.
- LOAD, 1 cycle: SPI_DATA_IN = latched word[FRAME_IDX]; SPI_START=0. Go to PULSE.
- PULSE, exactly 3 cycles: SPI_START=1, so the master's 2-flop edge detector sees a clean 0→1. Go to WAIT_BUSY.
- WAIT_BUSY: SPI_START=0. SPI_BUSY=1 goes to WAIT_DONE.
- WAIT_DONE: on SPI_BUSY=0 with SPI_VALID=1, capture SPI_DATA_OUT into RESULTS word[FRAME_IDX] that cycle.
  - If FRAME_IDX = NUM_WORDS-1, go to FINISH.
  - Otherwise increment FRAME_IDX and go to GAP.
- GAP: count GAP_CYCLES, then go to LOAD.
- FINISH, 1 cycle: DONE=1, then go to IDLE. TRIGGER during FINISH is ignored; a new sequence needs TRIGGER high in IDLE.
- SPI_DATA_IN stays constant from LOAD until leaving WAIT_DONE; the master samples it on the opposite edge.
- Timeout:
  - A counter clears on entry to WAIT_BUSY and to WAIT_DONE, and increments every cycle in those states.
  - Reaching TIMEOUT_CYCLES sets ERROR=1 and goes to FINISH; remaining frames are skipped.
  - RESULTS words for the aborted frame and all later frames keep their previous values.
- ERROR holds until the next accepted TRIGGER.
- TRIGGER while BUSY=1 is ignored. TRIGGER held high continuously restarts a sequence each time IDLE is reached.
- FRAME_IDX width is fixed at 4 bits, zero-extended; it holds its last value in IDLE.

## Timing
- Reset values: SPI_START=0, SPI_DATA_IN=0, RESULTS=0, FRAME_IDX=0, BUSY=0, DONE=0, ERROR=0, state IDLE, counters 0.
- RST asserted mid-sequence:
  - Outputs reach reset values the next cycle.
  - SPI_START drops immediately; no further frames are issued.
  - The in-flight master frame is not waited on.
- TRIGGER sampled at cycle t: LOAD at t+1, SPI_START high for t+2..t+4, WAIT_BUSY from t+5.
- Capture cycle is the first cycle with SPI_BUSY=0 and SPI_VALID=1 in WAIT_DONE. RESULTS updates on the following edge.
- DONE pulses the cycle after the final capture, or the cycle after a timeout. BUSY falls in the same cycle DONE falls.
- Gap between SPI_BUSY fall and the next SPI_START rise = 1 (capture) + GAP_CYCLES + 1 (LOAD) cycles.

## Test plan
- Normal sequence, NUM_WORDS=4. CMDS={0x9000,0x8800,0x1234,0xA5A5}, master model echoes ~cmd.
  - Exactly 4 START pulses, each 3 cycles, with DATA_IN in order 0x9000,0x8800,0x1234,0xA5A5.
  - RESULTS={0x6FFF,0x77FF,0xEDCB,0x5A5A}; one DONE pulse; ERROR=0.
- Gap check, GAP_CYCLES=32: SPI_BUSY fall to next SPI_START rise = 34 cycles on every frame.
- Timeout, master EN held low so BUSY never rises, TIMEOUT_CYCLES=1024:
  - DONE occurs 1024 cycles after entering WAIT_BUSY, with ERROR=1.
  - RESULTS unchanged from the prior run; a following good run clears ERROR.
- Retrigger while busy: TRIGGER pulses during frame 2 are ignored (still exactly 4 frames). CMDS changed mid-run still sends the latched words.
- Reset mid-frame: RST during WAIT_DONE of frame 1.
  - Next cycle all outputs are 0.
  - No START until a new TRIGGER; the next sequence begins at FRAME_IDX 0.
- NUM_WORDS=1, GAP_CYCLES=1, TRIGGER held high: back-to-back single-frame sequences, DONE every frame, FINISH→IDLE→LOAD spacing of 2 cycles.
